pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Hazard controller for the 5-stage MIPS pipeline. It sequences stalls and flushes across PC, IF/ID and ID/EX, and generates the EX-stage operand-forwarding selects.
- Load-use hazards: PC and IF/ID are frozen for one cycle and a bubble is inserted into ID/EX.
- Taken branches: younger instructions are squashed for a parameterised number of cycles.
- Free-running stall and flush event counters support performance analysis.

Parameters:
BRANCH_PENALTY, 2, number of consecutive cycles flush is asserted after a taken branch (legal 1..3)
CNT_W, 16, width of the stall and flush event counters

Ports:
clk  input  1  pipeline clock, all state on rising edge
rst  input  1  asynchronous active-high reset
ifid_rs  input  5  IF/ID instruction [25:21]
ifid_rt  input  5  IF/ID instruction [20:16]
idex_rs  input  5  ID/EX instruction [25:21]
idex_rt  input  5  ID/EX instruction [20:16]
idex_memread  input  1  ID/EX control bit 1 (memread)
exmem_wen  input  1  EX/MEM control bit 2 (register write enable)
exmem_rd  input  5  EX/MEM destination register (RegDst mux output)
memwb_wen  input  1  MEM/WB control bit 2
memwb_rd  input  5  MEM/WB write register
branch_taken  input  1  EX-stage branch resolved taken (pc_control & zero)
pc_write  output  1  1 = PC may update
ifid_write  output  1  1 = IF/ID may load
idex_bubble  output  1  1 = zero the ID/EX control word this edge
flush  output  1  1 = load IF/ID with NOP (32'h0)
fwd_a  output  2  ALU A select: 00 regfile, 10 EX/MEM ALU out, 01 MEM/WB writeback data
fwd_b  output  2  ALU B (pre-ALUSrc) select, same encoding
state  output  2  FSM state, debug
stall_cnt  output  CNT_W  cycles with pc_write=0
flush_cnt  output  CNT_W  taken branches accepted

Behaviour:
- Forwarding (combinational, independent of FSM):
  - fwd_a=10 if exmem_wen && exmem_rd!=0 && exmem_rd==idex_rs.
  - Otherwise fwd_a=01 if memwb_wen && memwb_rd!=0 && memwb_rd==idex_rs.
  - Otherwise fwd_a=00.
  - fwd_b uses the same rules with idex_rt.
  - EX/MEM always wins over MEM/WB. Register $0 is never forwarded.
- Load-use detect: lu = idex_memread && idex_rt!=0 && (idex_rt==ifid_rs || idex_rt==ifid_rt).
- FSM states: RUN=00, LU_STALL=01, FLUSH=10. Encoding 11 is unreachable; if it occurs, next state is RUN.
- Outputs are Mealy (state + current inputs). Default outputs: pc_write=1, ifid_write=1, idex_bubble=0, flush=0.
- RUN:
  - branch_taken (priority over lu): flush=1, idex_bubble=1, pc_write=1.
    - Penalty counter loads BRANCH_PENALTY-1.
    - Next state is FLUSH if BRANCH_PENALTY>1, else RUN.
    - flush_cnt increments.
  - else lu: pc_write=0, ifid_write=0, idex_bubble=1. Next state LU_STALL.
  - else: stay RUN with default outputs.
- LU_STALL: default outputs; next state RUN. A branch_taken here is handled exactly as in RUN; lu is not re-evaluated here.
- FLUSH:
  - flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
  - Penalty counter decrements each cycle; when it is 1 on this edge, next state is RUN.
  - branch_taken and lu are ignored (they come from squashed instructions).
- Counters:
  - stall_cnt increments on every cycle with pc_write=0.
  - Both counters saturate at all-ones and never wrap.
- Reset:
  - Immediate: state=RUN, penalty counter=0, stall_cnt=0, flush_cnt=0.
  - With idle inputs the outputs are pc_write=1, ifid_write=1, idex_bubble=0, flush=0, fwd_a=fwd_b=00.
  - Reset mid-FLUSH or mid-LU_STALL aborts to RUN in the same instant; no partial flush continues after release.
- Latency: stall and flush take effect on the same edge as detection (zero-cycle control).

Test Plan:
- exmem_wen=1, exmem_rd=5, memwb_wen=1, memwb_rd=5, idex_rs=5 -> fwd_a=10. Then exmem_wen=0 -> fwd_a=01. Then exmem_rd=memwb_rd=0 with idex_rs=0 -> fwd_a=00.
- idex_memread=1, idex_rt=3, ifid_rt=3, state RUN:
  - same cycle: pc_write=0, ifid_write=0, idex_bubble=1;
  - next cycle: state=01, pc_write=1;
  - stall_cnt=1.
- BRANCH_PENALTY=2, branch_taken=1 for one cycle:
  - flush=1 for exactly 2 cycles, state sequence 00,10,00;
  - flush_cnt=1;
  - branch_taken asserted during the second flush cycle is ignored (flush_cnt stays 1).
- branch_taken=1 and lu=1 together in RUN -> flush path only: pc_write=1, stall_cnt unchanged, state=10.
- CNT_W=4, 20 back-to-back load-use stalls -> stall_cnt holds at 15.
- rst pulsed during the first FLUSH cycle (BRANCH_PENALTY=3) -> state=00 and flush=0 immediately, counters=0, normal operation on the next edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard controller for a 5-stage MIPS pipeline. Produces same-cycle
//   stall/bubble/flush controls for PC, IF/ID and ID/EX, plus EX-stage
//   operand forwarding selects, and keeps saturating stall/flush counters.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   ifid_rs/ifid_rt       source registers of the instruction in IF/ID
//   idex_rs/idex_rt       source registers of the instruction in ID/EX
//   idex_memread          ID/EX instruction is a load
//   exmem_wen/exmem_rd    EX/MEM register write enable / destination
//   memwb_wen/memwb_rd    MEM/WB register write enable / destination
//   branch_taken          EX-stage branch resolved taken
//   pc_write, ifid_write  1 = register may update
//   idex_bubble           1 = zero ID/EX control word this edge
//   flush                 1 = load IF/ID with NOP
//   fwd_a, fwd_b          00 regfile, 10 EX/MEM, 01 MEM/WB
//   state                 FSM state (debug)
//   stall_cnt, flush_cnt  saturating event counters
module pipeline_hazard_ctrl #(
  parameter int unsigned BRANCH_PENALTY = 2,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic [4:0]       idex_rs,
  input  logic [4:0]       idex_rt,
  input  logic             idex_memread,
  input  logic             exmem_wen,
  input  logic [4:0]       exmem_rd,
  input  logic             memwb_wen,
  input  logic [4:0]       memwb_rd,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    FLUSH    = 2'b10
  } state_e;

  localparam logic [1:0]       PEN_LOAD = 2'(BRANCH_PENALTY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       pen_q, pen_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;
  logic             branch_accept;

  // Forwarding: EX/MEM result is younger, so it wins over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    if (exmem_wen && exmem_rd != 5'd0 && exmem_rd == idex_rs)
      fwd_a = 2'b10;
    else if (memwb_wen && memwb_rd != 5'd0 && memwb_rd == idex_rs)
      fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (exmem_wen && exmem_rd != 5'd0 && exmem_rd == idex_rt)
      fwd_b = 2'b10;
    else if (memwb_wen && memwb_rd != 5'd0 && memwb_rd == idex_rt)
      fwd_b = 2'b01;
  end

  assign lu = idex_memread && (idex_rt != 5'd0) &&
              ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  // Mealy control: outputs depend on current state and current inputs so
  // that stalls and flushes act on the same edge as detection.
  always_comb begin
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    idex_bubble   = 1'b0;
    flush         = 1'b0;
    branch_accept = 1'b0;
    state_d       = state_q;
    pen_d         = pen_q;
    case (state_q)
      RUN, LU_STALL: begin
        if (branch_taken) begin
          flush         = 1'b1;
          idex_bubble   = 1'b1;
          branch_accept = 1'b1;
          pen_d         = PEN_LOAD;
          state_d       = (BRANCH_PENALTY > 1) ? FLUSH : RUN;
        end else if (state_q == RUN && lu) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          state_d     = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        // Inputs here belong to squashed instructions and are ignored.
        flush       = 1'b1;
        idex_bubble = 1'b1;
        if (pen_q <= 2'd1) begin
          pen_d   = 2'd0;
          state_d = RUN;
        end else begin
          pen_d = pen_q - 2'd1;
        end
      end
      default: begin
        pen_d   = 2'd0;
        state_d = RUN;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (branch_accept && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      pen_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pen_q       <= pen_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, exmem_rd, memwb_rd;
  logic       idex_memread, exmem_wen, memwb_wen, branch_taken;

  // Three instances: [0] penalty 2 / 16-bit, [1] penalty 3 / 4-bit,
  // [2] penalty 1 / 8-bit. All share the same stimulus.
  logic        g_pcw[3], g_ifw[3], g_bub[3], g_fl[3];
  logic [1:0]  g_fa[3], g_fb[3], g_st[3];
  logic [15:0] g_sc[3], g_fc[3];
  logic [15:0] sc0, fc0;
  logic [3:0]  sc1, fc1;
  logic [7:0]  sc2, fc2;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.BRANCH_PENALTY(2), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_memread(idex_memread),
    .exmem_wen(exmem_wen), .exmem_rd(exmem_rd), .memwb_wen(memwb_wen),
    .memwb_rd(memwb_rd), .branch_taken(branch_taken),
    .pc_write(g_pcw[0]), .ifid_write(g_ifw[0]), .idex_bubble(g_bub[0]),
    .flush(g_fl[0]), .fwd_a(g_fa[0]), .fwd_b(g_fb[0]), .state(g_st[0]),
    .stall_cnt(sc0), .flush_cnt(fc0));

  pipeline_hazard_ctrl #(.BRANCH_PENALTY(3), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_memread(idex_memread),
    .exmem_wen(exmem_wen), .exmem_rd(exmem_rd), .memwb_wen(memwb_wen),
    .memwb_rd(memwb_rd), .branch_taken(branch_taken),
    .pc_write(g_pcw[1]), .ifid_write(g_ifw[1]), .idex_bubble(g_bub[1]),
    .flush(g_fl[1]), .fwd_a(g_fa[1]), .fwd_b(g_fb[1]), .state(g_st[1]),
    .stall_cnt(sc1), .flush_cnt(fc1));

  pipeline_hazard_ctrl #(.BRANCH_PENALTY(1), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_memread(idex_memread),
    .exmem_wen(exmem_wen), .exmem_rd(exmem_rd), .memwb_wen(memwb_wen),
    .memwb_rd(memwb_rd), .branch_taken(branch_taken),
    .pc_write(g_pcw[2]), .ifid_write(g_ifw[2]), .idex_bubble(g_bub[2]),
    .flush(g_fl[2]), .fwd_a(g_fa[2]), .fwd_b(g_fb[2]), .state(g_st[2]),
    .stall_cnt(sc2), .flush_cnt(fc2));

  assign g_sc[0] = sc0;
  assign g_fc[0] = fc0;
  assign g_sc[1] = {12'd0, sc1};
  assign g_fc[1] = {12'd0, fc1};
  assign g_sc[2] = {8'd0, sc2};
  assign g_fc[2] = {8'd0, fc2};

  // ---------------- behavioural reference model ----------------
  // Tracks "cycles of flush still owed" and "a load-use stall just happened".
  int unsigned pen_of[3] = '{2, 3, 1};
  int unsigned max_of[3] = '{65535, 15, 255};
  int unsigned m_left[3];
  int unsigned m_sc[3];
  int unsigned m_fc[3];
  bit          m_js[3];

  logic m_lu;
  assign m_lu = idex_memread && idex_rt != 0 &&
                (idex_rt == ifid_rs || idex_rt == ifid_rt);

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_left[i] <= 0; m_js[i] <= 0; m_sc[i] <= 0; m_fc[i] <= 0;
      end else if (m_left[i] > 0) begin
        m_left[i] <= m_left[i] - 1; m_js[i] <= 0;
      end else if (branch_taken) begin
        m_left[i] <= pen_of[i] - 1; m_js[i] <= 0;
        m_fc[i]   <= (m_fc[i] < max_of[i]) ? m_fc[i] + 1 : max_of[i];
      end else if (!m_js[i] && m_lu) begin
        m_js[i] <= 1;
        m_sc[i] <= (m_sc[i] < max_of[i]) ? m_sc[i] + 1 : max_of[i];
      end else begin
        m_js[i] <= 0;
      end
    end
  end

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (exmem_wen && exmem_rd != 0 && exmem_rd == src) return 2'b10;
    if (memwb_wen && memwb_rd != 0 && memwb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic set_idle();
    ifid_rs = 0; ifid_rt = 0; idex_rs = 0; idex_rt = 0;
    idex_memread = 0; exmem_wen = 0; exmem_rd = 0;
    memwb_wen = 0; memwb_rd = 0; branch_taken = 0;
  endtask

  task automatic idle_cycles(input int n);
    set_idle();
    repeat (n) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    @(negedge clk); #1;
    total++; if (g_pcw[0] !== 1'b1) begin bad++; $display("FAIL reset_pcw got=%b exp=1", g_pcw[0]); end
    total++; if (g_ifw[0] !== 1'b1) begin bad++; $display("FAIL reset_ifw got=%b exp=1", g_ifw[0]); end
    total++; if (g_bub[0] !== 1'b0) begin bad++; $display("FAIL reset_bub got=%b exp=0", g_bub[0]); end
    total++; if (g_fl[0] !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", g_fl[0]); end
    total++; if (g_fa[0] !== 2'b00 || g_fb[0] !== 2'b00) begin bad++; $display("FAIL reset_fwd got=%b/%b exp=00/00", g_fa[0], g_fb[0]); end
    total++; if (g_st[0] !== 2'b00) begin bad++; $display("FAIL reset_state got=%b exp=00", g_st[0]); end
    total++; if (g_sc[0] !== 16'd0 || g_fc[0] !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", g_sc[0], g_fc[0]); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_forwarding();
    exmem_wen = 1; exmem_rd = 5; memwb_wen = 1; memwb_rd = 5; idex_rs = 5; idex_rt = 5;
    #1;
    total++; if (g_fa[0] !== 2'b10) begin bad++; $display("FAIL fwd_a_exmem got=%b exp=10", g_fa[0]); end
    total++; if (g_fb[0] !== 2'b10) begin bad++; $display("FAIL fwd_b_exmem got=%b exp=10", g_fb[0]); end
    exmem_wen = 0;
    #1;
    total++; if (g_fa[0] !== 2'b01) begin bad++; $display("FAIL fwd_a_memwb got=%b exp=01", g_fa[0]); end
    total++; if (g_fb[0] !== 2'b01) begin bad++; $display("FAIL fwd_b_memwb got=%b exp=01", g_fb[0]); end
    exmem_wen = 1; exmem_rd = 0; memwb_rd = 0; idex_rs = 0; idex_rt = 0;
    #1;
    total++; if (g_fa[0] !== 2'b00) begin bad++; $display("FAIL fwd_a_zero got=%b exp=00", g_fa[0]); end
    total++; if (g_fb[0] !== 2'b00) begin bad++; $display("FAIL fwd_b_zero got=%b exp=00", g_fb[0]); end
    idle_cycles(1);
  endtask

  task automatic test_load_use();
    idex_memread = 1; idex_rt = 3; ifid_rt = 3; ifid_rs = 0;
    #1;
    total++; if (g_pcw[0] !== 1'b0) begin bad++; $display("FAIL lu_pcw got=%b exp=0", g_pcw[0]); end
    total++; if (g_ifw[0] !== 1'b0) begin bad++; $display("FAIL lu_ifw got=%b exp=0", g_ifw[0]); end
    total++; if (g_bub[0] !== 1'b1) begin bad++; $display("FAIL lu_bub got=%b exp=1", g_bub[0]); end
    @(negedge clk); #1;
    total++; if (g_st[0] !== 2'b01) begin bad++; $display("FAIL lu_state got=%b exp=01", g_st[0]); end
    total++; if (g_pcw[0] !== 1'b1) begin bad++; $display("FAIL lu_next_pcw got=%b exp=1", g_pcw[0]); end
    total++; if (g_sc[0] !== 16'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=1", g_sc[0]); end
    idle_cycles(2);
  endtask

  task automatic test_branch();
    branch_taken = 1;
    #1;
    total++; if (g_fl[0] !== 1'b1 || g_st[0] !== 2'b00) begin bad++; $display("FAIL br_c0 got=flush%b st%b exp=flush1 st00", g_fl[0], g_st[0]); end
    @(negedge clk); #1;  // branch still asserted: must be ignored in FLUSH
    total++; if (g_fl[0] !== 1'b1 || g_st[0] !== 2'b10) begin bad++; $display("FAIL br_c1 got=flush%b st%b exp=flush1 st10", g_fl[0], g_st[0]); end
    total++; if (g_fc[0] !== 16'd1) begin bad++; $display("FAIL br_cnt1 got=%0d exp=1", g_fc[0]); end
    @(negedge clk);
    branch_taken = 0;
    #1;
    total++; if (g_fl[0] !== 1'b0 || g_st[0] !== 2'b00) begin bad++; $display("FAIL br_c2 got=flush%b st%b exp=flush0 st00", g_fl[0], g_st[0]); end
    total++; if (g_fc[0] !== 16'd1) begin bad++; $display("FAIL br_cnt_ignored got=%0d exp=1", g_fc[0]); end
    idle_cycles(3);
  endtask

  task automatic test_branch_lu_priority();
    int unsigned sc_before;
    sc_before = m_sc[0];
    branch_taken = 1; idex_memread = 1; idex_rt = 3; ifid_rt = 3;
    #1;
    total++; if (g_pcw[0] !== 1'b1 || g_fl[0] !== 1'b1) begin bad++; $display("FAIL prio_c0 got=pcw%b flush%b exp=pcw1 flush1", g_pcw[0], g_fl[0]); end
    @(negedge clk);
    set_idle();
    #1;
    total++; if (g_st[0] !== 2'b10) begin bad++; $display("FAIL prio_state got=%b exp=10", g_st[0]); end
    total++; if (g_sc[0] !== 16'(sc_before)) begin bad++; $display("FAIL prio_stall_cnt got=%0d exp=%0d", g_sc[0], sc_before); end
    idle_cycles(4);
  endtask

  task automatic test_stall_saturation();
    idex_memread = 1; idex_rt = 7; ifid_rs = 7;
    repeat (40) @(negedge clk);
    #1;
    total++; if (g_sc[1] !== 16'd15) begin bad++; $display("FAIL sat_stall_cnt4 got=%0d exp=15", g_sc[1]); end
    total++; if (g_sc[0] !== 16'(m_sc[0])) begin bad++; $display("FAIL sat_stall_cnt16 got=%0d exp=%0d", g_sc[0], m_sc[0]); end
    idle_cycles(4);
  endtask

  task automatic test_reset_mid_flush();
    branch_taken = 1;
    @(negedge clk);
    branch_taken = 0;
    #1;
    total++; if (g_st[1] !== 2'b10 || g_fl[1] !== 1'b1) begin bad++; $display("FAIL rmf_pre got=st%b flush%b exp=st10 flush1", g_st[1], g_fl[1]); end
    #1 rst = 1'b1;
    #1;
    total++; if (g_st[1] !== 2'b00 || g_fl[1] !== 1'b0) begin bad++; $display("FAIL rmf_abort got=st%b flush%b exp=st00 flush0", g_st[1], g_fl[1]); end
    total++; if (g_sc[1] !== 16'd0 || g_fc[1] !== 16'd0) begin bad++; $display("FAIL rmf_cnt got=%0d/%0d exp=0/0", g_sc[1], g_fc[1]); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    total++; if (g_st[1] !== 2'b00 || g_fl[1] !== 1'b0) begin bad++; $display("FAIL rmf_after got=st%b flush%b exp=st00 flush0", g_st[1], g_fl[1]); end
    @(negedge clk);
    branch_taken = 1;
    #1;
    total++; if (g_fl[1] !== 1'b1) begin bad++; $display("FAIL rmf_new_flush got=%b exp=1", g_fl[1]); end
    @(negedge clk);
    branch_taken = 0;
    #1;
    total++; if (g_fc[1] !== 16'd1 || g_st[1] !== 2'b10) begin bad++; $display("FAIL rmf_new_cnt got=%0d st%b exp=1 st10", g_fc[1], g_st[1]); end
    idle_cycles(4);
  endtask

  task automatic test_random();
    logic [15:0] e_sc, e_fc;
    logic        e_stall, e_fl;
    logic [1:0]  e_st;
    for (int n = 0; n < 400; n++) begin
      ifid_rs      = 5'($urandom_range(0, 3));
      ifid_rt      = 5'($urandom_range(0, 3));
      idex_rs      = 5'($urandom_range(0, 3));
      idex_rt      = 5'($urandom_range(0, 3));
      idex_memread = 1'($urandom_range(0, 1));
      exmem_wen    = 1'($urandom_range(0, 1));
      exmem_rd     = 5'($urandom_range(0, 3));
      memwb_wen    = 1'($urandom_range(0, 1));
      memwb_rd     = 5'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 5) == 0);
      #1;
      for (int i = 0; i < 3; i++) begin
        e_fl    = (m_left[i] > 0) || branch_taken;
        e_stall = !e_fl && !m_js[i] && m_lu;
        e_st    = (m_left[i] > 0) ? 2'b10 : (m_js[i] ? 2'b01 : 2'b00);
        e_sc    = 16'(m_sc[i]);
        e_fc    = 16'(m_fc[i]);
        total++; if (g_pcw[i] !== !e_stall) begin bad++; $display("FAIL rnd_pcw[%0d] n=%0d got=%b exp=%b", i, n, g_pcw[i], !e_stall); end
        total++; if (g_ifw[i] !== !e_stall) begin bad++; $display("FAIL rnd_ifw[%0d] n=%0d got=%b exp=%b", i, n, g_ifw[i], !e_stall); end
        total++; if (g_bub[i] !== (e_fl || e_stall)) begin bad++; $display("FAIL rnd_bub[%0d] n=%0d got=%b exp=%b", i, n, g_bub[i], e_fl || e_stall); end
        total++; if (g_fl[i] !== e_fl) begin bad++; $display("FAIL rnd_flush[%0d] n=%0d got=%b exp=%b", i, n, g_fl[i], e_fl); end
        total++; if (g_fa[i] !== exp_fwd(idex_rs)) begin bad++; $display("FAIL rnd_fwd_a[%0d] n=%0d got=%b exp=%b", i, n, g_fa[i], exp_fwd(idex_rs)); end
        total++; if (g_fb[i] !== exp_fwd(idex_rt)) begin bad++; $display("FAIL rnd_fwd_b[%0d] n=%0d got=%b exp=%b", i, n, g_fb[i], exp_fwd(idex_rt)); end
        total++; if (g_st[i] !== e_st) begin bad++; $display("FAIL rnd_state[%0d] n=%0d got=%b exp=%b", i, n, g_st[i], e_st); end
        total++; if (g_sc[i] !== e_sc || g_fc[i] !== e_fc) begin bad++; $display("FAIL rnd_cnt[%0d] n=%0d got=%0d/%0d exp=%0d/%0d", i, n, g_sc[i], g_fc[i], e_sc, e_fc); end
      end
      @(negedge clk);
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_branch_lu_priority();
    test_stall_saturation();
    test_reset_mid_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
